fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Owns the framebuffer RAM write port (color, 20-bit address {y,x}, write enable) in front of the video output block.
- Shares that port between two pixel requesters (A, B) using valid/ready handshakes and round-robin arbitration.
- Contains a clear-screen sequencer that sweeps the full active area with one colour and has absolute priority over both requesters.

Parameters:
- H_ACTIVE, 640, visible pixels per line; x range 0..H_ACTIVE-1
- V_ACTIVE, 480, visible lines; y range 0..V_ACTIVE-1
- COORD_W, 10, width of each coordinate field; address width = 2*COORD_W
- COLOR_W, 4, palette index width

Ports:
- clock  in  1  write-side clock
- reset  in  1  asynchronous, active-high
- clear_start  in  1  one-cycle pulse; requests a full-screen clear
- clear_color  in  COLOR_W  fill colour; sampled on the accepted clear_start
- clear_busy  out  1  high while a clear sweep is in progress
- a_valid  in  1  requester A has a pixel
- a_ready  out  1  A's pixel accepted this cycle when a_valid && a_ready
- a_x, a_y  in  COORD_W each  A's pixel coordinates
- a_color  in  COLOR_W  A's pixel colour
- b_valid, b_ready, b_x, b_y, b_color: same as A, for requester B
- fb_color  out  COLOR_W  write data to framebuffer
- fb_address  out  2*COORD_W  write address {y,x}
- fb_write_enable  out  1  one-cycle write strobe

Behaviour:
- Reset (async): state IDLE, clear_busy=0, fb_write_enable=0, fb_address=0, fb_color=0, last_grant=B (A wins first tie), sweep counters=0.
- All fb_* outputs are registered. An accepted pixel or clear step produces fb_write_enable=1 on the next clock edge, so latency is 1 cycle. At most one write per cycle.
- The FSM has two states, IDLE and CLEAR.
- IDLE, clear_start=1:
  - Capture clear_color and zero the counters (x=0, y=0).
  - Go to CLEAR.
  - a_ready=b_ready=0 in that same cycle, so clear wins a simultaneous request.
- IDLE, no clear_start: arbitration for the cycle.
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the one not equal to last_grant, then update last_grant.
  - The ungranted ready is 0. Ready signals are combinational from valid, state and clear_start.
- IDLE, accepted pixel writes:
  - If x<H_ACTIVE and y<V_ACTIVE: next cycle fb_address={y,x}, fb_color=color, fb_write_enable=1.
  - Out-of-range pixels are accepted (ready=1), dropped silently (no write), and still update last_grant.
- CLEAR:
  - clear_busy=1 and a_ready=b_ready=0.
  - Each cycle issues a write of clear_color at {y,x}.
  - x increments; when x=H_ACTIVE-1, x wraps to 0 and y increments.
  - After the write at (H_ACTIVE-1, V_ACTIVE-1): return to IDLE and clear_busy=0.
  - A sweep is exactly H_ACTIVE*V_ACTIVE writes in consecutive cycles (307200 at defaults).
- clear_busy timing: rises the cycle after clear_start is accepted and falls with the final write strobe. Requesters may be accepted in the cycle after that.
- clear_start while in CLEAR is ignored; the sweep does not restart and clear_color is not re-sampled.
- Reset mid-sweep: everything returns to reset values immediately, the sweep is abandoned, and no further writes occur.
- Requester inputs need only be stable while valid && !ready. The block does not assume valid is held, but requesters must hold it per the valid/ready rule.
- fb_address and fb_color hold their last values when fb_write_enable=0.

Decomposition:
- Shared package holds:
  - H_ACTIVE, V_ACTIVE, COORD_W, COLOR_W constants (shared with the video timing and RAM blocks);
  - the FSM state enum {IDLE, CLEAR};
  - a pixel-request struct {x, y, color}.
- One sub-module is natural: fb_rr_arb2, a 2-way round-robin arbiter (valid in, grant out, last_grant register, enable input gated by the FSM).

Test Plan:
- Reset, then A pulses valid with x=5, y=7, color=9 → a_ready=1 that cycle; next cycle fb_write_enable=1, fb_address=(7<<10)|5, fb_color=9.
- A and B both held valid for 4 cycles → grants A,B,A,B; 4 writes with alternating colours; no gaps.
- clear_start with clear_color=3 → clear_busy rises next cycle. The first write is address 0, color 3. The write at count 640 has address 1<<10. The last write is address (479<<10)|639. Exactly 307200 strobes; clear_busy falls with the final strobe.
- clear_start asserted in the same cycle as a_valid → a_ready=0; A is stalled for the whole sweep and accepted the cycle after clear_busy falls.
- B sends x=640, y=0, then x=0, y=480 → both accepted (b_ready=1), zero write strobes.
- Assert reset 100 cycles into a clear → outputs at reset values immediately. No strobes after reset. A subsequent A request is written normally.

Source files
------------

// File: rtl/fb_write_arbiter_pkg.sv
// Shared framebuffer geometry, palette width and write-path types used by the
// video timing, RAM and write arbiter blocks.
package fb_write_arbiter_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOR_W  = 4;
  localparam int unsigned ADDR_W   = 2 * COORD_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } grant_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  function automatic logic [ADDR_W-1:0] pack_address(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Pixel requester handshakes and framebuffer write port owned by fb_write_arbiter.
interface fb_write_arbiter_if;
  import fb_write_arbiter_pkg::*;

  logic               a_valid;
  logic               a_ready;
  logic [COORD_W-1:0] a_x;
  logic [COORD_W-1:0] a_y;
  logic [COLOR_W-1:0] a_color;

  logic               b_valid;
  logic               b_ready;
  logic [COORD_W-1:0] b_x;
  logic [COORD_W-1:0] b_y;
  logic [COLOR_W-1:0] b_color;

  logic [COLOR_W-1:0] fb_color;
  logic [ADDR_W-1:0]  fb_address;
  logic               fb_write_enable;

  modport master (
    output a_valid, a_x, a_y, a_color,
    output b_valid, b_x, b_y, b_color,
    input  a_ready, b_ready,
    input  fb_color, fb_address, fb_write_enable
  );

  modport slave (
    input  a_valid, a_x, a_y, a_color,
    input  b_valid, b_x, b_y, b_color,
    output a_ready, b_ready,
    output fb_color, fb_address, fb_write_enable
  );

endinterface

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin arbiter; grant[0]=A, grant[1]=B. On a tie the requester
// that did not win last time is granted.
module fb_rr_arb2
  import fb_write_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  grant_t last_grant;

  always_comb begin
    grant = '0;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == GRANT_B) ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_B;
    end else if (grant[0]) begin
      last_grant <= GRANT_A;
    end else if (grant[1]) begin
      last_grant <= GRANT_B;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: round-robin between requesters A and B, with a
// full-screen clear sweep that locks both requesters out while it runs.
module fb_write_arbiter #(
  parameter int unsigned H_ACTIVE = fb_write_arbiter_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = fb_write_arbiter_pkg::V_ACTIVE
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  clear_start,
  input  logic [fb_write_arbiter_pkg::COLOR_W-1:0] clear_color,
  output logic                                  clear_busy,
  fb_write_arbiter_if.slave                     bus
);
  import fb_write_arbiter_pkg::*;

  state_t             state;
  logic [COLOR_W-1:0] sweep_color;
  logic [COORD_W-1:0] sweep_x;
  logic [COORD_W-1:0] sweep_y;
  logic [1:0]         grant;
  logic               arb_enable;
  logic               in_range;
  logic               x_last;
  logic               y_last;
  pixel_t             req;

  // A clear request in IDLE pre-empts arbitration in the same cycle.
  assign arb_enable = (state == IDLE) && !clear_start;

  fb_rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_enable),
    .valid  ({bus.b_valid, bus.a_valid}),
    .grant  (grant)
  );

  assign bus.a_ready = grant[0];
  assign bus.b_ready = grant[1];

  always_comb begin
    req = '0;
    if (grant[1]) begin
      req = '{x: bus.b_x, y: bus.b_y, color: bus.b_color};
    end else begin
      req = '{x: bus.a_x, y: bus.a_y, color: bus.a_color};
    end
  end

  assign in_range = (32'(req.x) < H_ACTIVE) && (32'(req.y) < V_ACTIVE);
  assign x_last   = (sweep_x == COORD_W'(H_ACTIVE - 1));
  assign y_last   = (sweep_y == COORD_W'(V_ACTIVE - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      clear_busy          <= 1'b0;
      sweep_color         <= '0;
      sweep_x             <= '0;
      sweep_y             <= '0;
      bus.fb_write_enable <= 1'b0;
      bus.fb_address      <= '0;
      bus.fb_color        <= '0;
    end else begin
      bus.fb_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state       <= CLEAR;
            clear_busy  <= 1'b1;
            sweep_color <= clear_color;
            sweep_x     <= '0;
            sweep_y     <= '0;
          end else if ((|grant) && in_range) begin
            bus.fb_write_enable <= 1'b1;
            bus.fb_address      <= pack_address(req.x, req.y);
            bus.fb_color        <= req.color;
          end
        end
        CLEAR: begin
          bus.fb_write_enable <= 1'b1;
          bus.fb_address      <= pack_address(sweep_x, sweep_y);
          bus.fb_color        <= sweep_color;
          if (x_last) begin
            sweep_x <= '0;
            // Busy drops at the same edge that presents the final strobe.
            if (y_last) begin
              state      <= IDLE;
              clear_busy <= 1'b0;
            end else begin
              sweep_y <= sweep_y + 1'b1;
            end
          end else begin
            sweep_x <= sweep_x + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on a reduced 16x8 screen so a full clear
// sweep stays short.
module tb_fb_write_arbiter;
  import fb_write_arbiter_pkg::*;

  localparam int unsigned H = 16;
  localparam int unsigned V = 8;
  localparam int unsigned N = H * V;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               clear_start = 1'b0;
  logic [COLOR_W-1:0] clear_color = '0;
  logic               clear_busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  fb_write_arbiter_if bus();

  fb_write_arbiter #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int unsigned x, input int unsigned y);
    return (y << 10) | x;
  endfunction

  task automatic check_write(input string tag, input int unsigned x, input int unsigned y,
                             input int unsigned color);
    check_value({tag, "_we"}, 32'(bus.fb_write_enable), 1);
    check_value({tag, "_addr"}, 32'(bus.fb_address), addr_of(x, y));
    check_value({tag, "_color"}, 32'(bus.fb_color), color);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.a_valid = 1'b0; bus.a_x = '0; bus.a_y = '0; bus.a_color = '0;
    bus.b_valid = 1'b0; bus.b_x = '0; bus.b_y = '0; bus.b_color = '0;

    // Reset state
    tick; tick;
    check_value("rst_we", 32'(bus.fb_write_enable), 0);
    check_value("rst_addr", 32'(bus.fb_address), 0);
    check_value("rst_color", 32'(bus.fb_color), 0);
    check_value("rst_busy", 32'(clear_busy), 0);
    reset = 1'b0;
    tick;

    // Single A pixel
    bus.a_valid = 1'b1; bus.a_x = 10'd5; bus.a_y = 10'd7; bus.a_color = 4'd9;
    #1;
    check_value("single_a_ready", 32'(bus.a_ready), 1);
    check_value("single_b_ready", 32'(bus.b_ready), 0);
    tick;
    bus.a_valid = 1'b0;
    check_write("single", 5, 7, 9);
    tick;
    check_value("single_idle_we", 32'(bus.fb_write_enable), 0);
    check_value("single_hold_addr", 32'(bus.fb_address), addr_of(5, 7));

    // Fresh reset so the tie sequence starts with A
    reset = 1'b1; #1; reset = 1'b0;
    tick;
    bus.a_valid = 1'b1; bus.a_x = 10'd1; bus.a_y = 10'd1; bus.a_color = 4'd1;
    bus.b_valid = 1'b1; bus.b_x = 10'd2; bus.b_y = 10'd2; bus.b_color = 4'd2;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_value("rr_a_ready", 32'(bus.a_ready), (i % 2 == 0) ? 1 : 0);
      check_value("rr_b_ready", 32'(bus.b_ready), (i % 2 == 0) ? 0 : 1);
      tick;
      if (i % 2 == 0) check_write("rr_a", 1, 1, 1);
      else            check_write("rr_b", 2, 2, 2);
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick;
    check_value("rr_idle_we", 32'(bus.fb_write_enable), 0);

    // Clear colliding with an A request, plus an ignored mid-sweep clear_start
    bus.a_valid = 1'b1; bus.a_x = 10'd3; bus.a_y = 10'd4; bus.a_color = 4'd5;
    clear_start = 1'b1; clear_color = 4'd3;
    #1;
    check_value("clr_start_a_ready", 32'(bus.a_ready), 0);
    tick;
    clear_start = 1'b0;
    check_value("clr_busy_rise", 32'(clear_busy), 1);
    check_value("clr_first_gap_we", 32'(bus.fb_write_enable), 0);
    check_value("clr_busy_a_ready", 32'(bus.a_ready), 0);
    for (int unsigned i = 0; i < N; i++) begin
      if (i == 20) begin clear_start = 1'b1; clear_color = 4'd7; end
      if (i == 21) clear_start = 1'b0;
      tick;
      check_write("clr", i % H, i / H, 3);
      check_value("clr_busy", 32'(clear_busy), (i == N - 1) ? 0 : 1);
      if (i != N - 1) check_value("clr_stall_a", 32'(bus.a_ready), 0);
    end
    check_value("clr_done_a_ready", 32'(bus.a_ready), 1);
    tick;
    bus.a_valid = 1'b0;
    check_write("clr_after_a", 3, 4, 5);
    check_value("clr_after_busy", 32'(clear_busy), 0);
    tick;
    check_value("clr_end_we", 32'(bus.fb_write_enable), 0);

    // B out-of-range pixels are accepted and dropped; the corner pixel is written
    bus.b_valid = 1'b1; bus.b_x = 10'(H); bus.b_y = 10'd0; bus.b_color = 4'd4;
    #1;
    check_value("oor_x_ready", 32'(bus.b_ready), 1);
    tick;
    check_value("oor_x_we", 32'(bus.fb_write_enable), 0);
    bus.b_x = 10'd0; bus.b_y = 10'(V);
    #1;
    check_value("oor_y_ready", 32'(bus.b_ready), 1);
    tick;
    check_value("oor_y_we", 32'(bus.fb_write_enable), 0);
    bus.b_x = 10'(H - 1); bus.b_y = 10'(V - 1); bus.b_color = 4'hA;
    #1;
    check_value("corner_ready", 32'(bus.b_ready), 1);
    tick;
    bus.b_valid = 1'b0;
    check_write("corner", H - 1, V - 1, 10);

    // Reset 100 cycles into a sweep
    clear_start = 1'b1; clear_color = 4'hC;
    tick;
    clear_start = 1'b0;
    repeat (100) tick;
    check_value("midrst_pre_we", 32'(bus.fb_write_enable), 1);
    check_value("midrst_pre_color", 32'(bus.fb_color), 32'hC);
    reset = 1'b1;
    #1;
    check_value("midrst_we", 32'(bus.fb_write_enable), 0);
    check_value("midrst_addr", 32'(bus.fb_address), 0);
    check_value("midrst_color", 32'(bus.fb_color), 0);
    check_value("midrst_busy", 32'(clear_busy), 0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_value("postrst_we", 32'(bus.fb_write_enable), 0);
      check_value("postrst_busy", 32'(clear_busy), 0);
    end
    bus.a_valid = 1'b1; bus.a_x = 10'd9; bus.a_y = 10'd2; bus.a_color = 4'd6;
    #1;
    check_value("postrst_a_ready", 32'(bus.a_ready), 1);
    tick;
    bus.a_valid = 1'b0;
    check_write("postrst_a", 9, 2, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
